// File: rtl/clock_pkg.sv
// Shared mode encoding for the clock sequencer and the display mux blink-field select.
package clock_pkg;

  localparam logic [1:0] MODE_RUN      = 2'b00;
  localparam logic [1:0] MODE_SET_HOUR = 2'b01;
  localparam logic [1:0] MODE_SET_MIN  = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN      = MODE_RUN,
    ST_SET_HOUR = MODE_SET_HOUR,
    ST_SET_MIN  = MODE_SET_MIN
  } clk_state_e;

  // Mode key advance order: RUN -> SET_HOUR -> SET_MIN -> RUN
  function automatic clk_state_e next_mode(input clk_state_e s);
    case (s)
      ST_RUN:      next_mode = ST_SET_HOUR;
      ST_SET_HOUR: next_mode = ST_SET_MIN;
      default:     next_mode = ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/clock_set_ctrl_key_step.sv
// Key press edge detect with optional hold-to-repeat (KEY_REPEAT_EN).
// step is a one-cycle pulse: the press edge, plus repeat pulses when enabled.
// clr discards any step in its cycle and disarms repeat until a fresh press.
module key_step
`ifdef KEY_REPEAT_EN
#(
  parameter int unsigned CNT_W   = 10,
  parameter int unsigned REP_DLY = 500,
  parameter int unsigned REP_PER = 100
)
`endif
(
  input  logic CP,
  input  logic nCR,
  input  logic key,
  input  logic clr,
  output logic step
);

  logic prev_q;
  logic press;

  // Previous key level for edge detection
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) prev_q <= 1'b0;
    else      prev_q <= key;
  end

  assign press = key & ~prev_q;

`ifdef KEY_REPEAT_EN
  logic             held_q, held_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_fire;

  // rep_cnt_q equals (cycles since press - 1); reload keeps it below REP_DLY
  assign rep_fire = held_q & key & (rep_cnt_q == CNT_W'(REP_DLY - 1));

  // Repeat arming and counter next-state
  always_comb begin
    held_d    = held_q;
    rep_cnt_d = rep_cnt_q;
    if (clr || !key) begin
      held_d    = 1'b0;
      rep_cnt_d = '0;
    end else if (press) begin
      held_d    = 1'b1;
      rep_cnt_d = '0;
    end else if (held_q) begin
      rep_cnt_d = rep_fire ? CNT_W'(REP_DLY - REP_PER) : rep_cnt_q + CNT_W'(1);
    end
  end

  // Repeat state registers
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      held_q    <= 1'b0;
      rep_cnt_q <= '0;
    end else begin
      held_q    <= held_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

  assign step = ~clr & (press | rep_fire);
`else
  assign step = ~clr & press;
`endif

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/enable sequencer for the seconds/minutes/hours chain.
// Optional hold-to-repeat on the adjust key: define KEY_REPEAT_EN.
// en_* are combinational from registered state and inputs; mode/blink/sec_clr are registered.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned IDLE_SEC = 10
`ifdef KEY_REPEAT_EN
  , parameter int unsigned CNT_W   = 10
  , parameter int unsigned REP_DLY = 500
  , parameter int unsigned REP_PER = 100
`endif
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       tick_1hz,
  input  logic       sec_tc,
  input  logic       min_tc,
  input  logic       key_mode,
  input  logic       key_adj,
  output logic       en_sec,
  output logic       en_min,
  output logic       en_hour,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int unsigned IDLE_W = $clog2(IDLE_SEC + 1);

  clk_state_e        state_q, state_d;
  logic              mode_prev_q;
  logic              mode_press;
  logic              in_set;
  logic              timeout;
  logic              adj_clr;
  logic              adj_step;
  logic              blink_q, blink_d;
  logic              sec_clr_q, sec_clr_d;
  logic [IDLE_W-1:0] idle_q, idle_d;

  assign mode_press = key_mode & ~mode_prev_q;
  assign in_set     = (state_q != ST_RUN);
  assign timeout    = in_set & tick_1hz & (idle_q == IDLE_W'(IDLE_SEC - 1));
  // Adjust steps are dropped in RUN and whenever the state is about to change
  assign adj_clr    = ~in_set | mode_press | timeout;

  key_step
`ifdef KEY_REPEAT_EN
  #(
    .CNT_W  (CNT_W),
    .REP_DLY(REP_DLY),
    .REP_PER(REP_PER)
  )
`endif
  u_adj (
    .CP  (CP),
    .nCR (nCR),
    .key (key_adj),
    .clr (adj_clr),
    .step(adj_step)
  );

  // Next state, idle timer, blink, and counter enables
  always_comb begin
    state_d   = state_q;
    blink_d   = blink_q;
    idle_d    = idle_q;
    sec_clr_d = 1'b0;
    en_sec    = 1'b0;
    en_min    = 1'b0;
    en_hour   = 1'b0;

    if (mode_press)   state_d = next_mode(state_q);
    else if (timeout) state_d = ST_RUN;

    sec_clr_d = (state_q == ST_SET_MIN) && (state_d == ST_RUN);

    if ((state_d != state_q) || (state_d == ST_RUN)) begin
      blink_d = 1'b0;
      idle_d  = '0;
    end else begin
      if (tick_1hz) blink_d = ~blink_q;
      if (adj_step)
        idle_d = '0;
      else if (tick_1hz && (idle_q != IDLE_W'(IDLE_SEC)))
        idle_d = idle_q + IDLE_W'(1);
    end

    case (state_q)
      ST_RUN: begin
        en_sec  = tick_1hz;
        en_min  = tick_1hz & sec_tc;
        en_hour = tick_1hz & sec_tc & min_tc;
      end
      ST_SET_HOUR: en_hour = adj_step;
      ST_SET_MIN:  en_min  = adj_step;
      default: ;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state_q     <= ST_RUN;
      mode_prev_q <= 1'b0;
      blink_q     <= 1'b0;
      sec_clr_q   <= 1'b0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      mode_prev_q <= key_mode;
      blink_q     <= blink_d;
      sec_clr_q   <= sec_clr_d;
      idle_q      <= idle_d;
    end
  end

  assign mode    = state_q;
  assign blink   = blink_q;
  assign sec_clr = sec_clr_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: vector table, corner sequences, random vs model.
module tb_clock_set_ctrl;

  localparam int IDLE_SEC = 10;
  localparam int REP_DLY  = 500;
  localparam int REP_PER  = 100;

  logic       CP, nCR;
  logic       tick_1hz, sec_tc, min_tc, key_mode, key_adj;
  logic       en_sec, en_min, en_hour, sec_clr, blink;
  logic [1:0] mode;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int m_mode, m_idle, m_hold;
  bit m_blink, m_sc, m_aprev, m_mprev, m_armed;

  typedef struct {
    logic [4:0] in;   // {tick, sec_tc, min_tc, key_mode, key_adj}
    logic [2:0] en;   // {en_sec, en_min, en_hour}
    logic [1:0] md;
    logic       bl;
    logic       sc;
  } vec_t;

  vec_t vecs[25];

  clock_set_ctrl dut (
    .CP(CP), .nCR(nCR), .tick_1hz(tick_1hz), .sec_tc(sec_tc), .min_tc(min_tc),
    .key_mode(key_mode), .key_adj(key_adj), .en_sec(en_sec), .en_min(en_min),
    .en_hour(en_hour), .sec_clr(sec_clr), .mode(mode), .blink(blink)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic [4:0] in, input logic [2:0] en,
                               input logic [1:0] md, input logic bl, input logic sc);
    vec_t v;
    v.in = in; v.en = en; v.md = md; v.bl = bl; v.sc = sc;
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_idle = 0; m_hold = 0;
    m_blink = 0; m_sc = 0; m_aprev = 0; m_mprev = 0; m_armed = 0;
  endtask

  task automatic apply_reset();
    @(negedge CP);
    nCR = 1'b0;
    {tick_1hz, sec_tc, min_tc, key_mode, key_adj} = 5'b0;
    #1;
    chk("rst_mode", 8'(mode), 8'd0);
    chk("rst_en", 8'({en_sec, en_min, en_hour}), 8'd0);
    chk("rst_blink_clr", 8'({blink, sec_clr}), 8'd0);
    repeat (2) @(negedge CP);
    nCR = 1'b1;
    model_reset();
  endtask

  // Drive one cycle of inputs, compare against the model, then advance the model
  task automatic do_cycle(input logic [4:0] in);
    bit t, s, m, km, ka, mp, ap, tmo, disc, rep, stp, e_s, e_m, e_h, chg;
    int nm;
    @(negedge CP);
    {tick_1hz, sec_tc, min_tc, key_mode, key_adj} = in;
    {t, s, m, km, ka} = in;
    #1;
    mp   = km && !m_mprev;
    ap   = ka && !m_aprev;
    tmo  = (m_mode != 0) && t && (m_idle == IDLE_SEC - 1);
    disc = (m_mode == 0) || mp || tmo;
    rep  = 0;
`ifdef KEY_REPEAT_EN
    rep  = m_armed && ka && (m_hold >= REP_DLY) && (((m_hold - REP_DLY) % REP_PER) == 0);
`endif
    stp  = !disc && (ap || rep);
    e_s  = (m_mode == 0) && t;
    e_m  = ((m_mode == 0) && t && s) || ((m_mode == 2) && stp);
    e_h  = ((m_mode == 0) && t && s && m) || ((m_mode == 1) && stp);
    chk("m_en_sec", 8'(en_sec), 8'(e_s));
    chk("m_en_min", 8'(en_min), 8'(e_m));
    chk("m_en_hour", 8'(en_hour), 8'(e_h));
    chk("m_mode", 8'(mode), 8'(m_mode));
    chk("m_blink", 8'(blink), 8'(m_blink));
    chk("m_sec_clr", 8'(sec_clr), 8'(m_sc));
    // model update
    nm   = mp ? (m_mode + 1) % 3 : (tmo ? 0 : m_mode);
    m_sc = (m_mode == 2) && (nm == 0);
    chg  = (nm != m_mode);
    if (chg || nm == 0) begin
      m_blink = 0; m_idle = 0;
    end else begin
      if (t) m_blink = !m_blink;
      if (stp) m_idle = 0;
      else if (t) m_idle++;
    end
    if (disc)         m_armed = 0;
    else if (ap)      begin m_armed = 1; m_hold = 1; end
    else if (!ka)     m_armed = 0;
    else if (m_armed) m_hold++;
    m_mode  = nm;
    m_aprev = ka;
    m_mprev = km;
  endtask

  initial begin
    int hits[$];
    logic km_l, ka_l;
    int ka_th;
    nCR = 1'b0;
    {tick_1hz, sec_tc, min_tc, key_mode, key_adj} = 5'b0;
    model_reset();

    vecs[0]  = mkv(5'b11100, 3'b111, 2'd0, 0, 0);
    vecs[1]  = mkv(5'b10100, 3'b100, 2'd0, 0, 0);
    vecs[2]  = mkv(5'b11000, 3'b110, 2'd0, 0, 0);
    vecs[3]  = mkv(5'b00010, 3'b000, 2'd0, 0, 0);
    vecs[4]  = mkv(5'b00000, 3'b000, 2'd1, 0, 0);
    vecs[5]  = mkv(5'b00001, 3'b001, 2'd1, 0, 0);
    vecs[6]  = mkv(5'b00001, 3'b000, 2'd1, 0, 0);
    vecs[7]  = mkv(5'b00000, 3'b000, 2'd1, 0, 0);
    vecs[8]  = mkv(5'b00001, 3'b001, 2'd1, 0, 0);
    vecs[9]  = mkv(5'b00000, 3'b000, 2'd1, 0, 0);
    vecs[10] = mkv(5'b00001, 3'b001, 2'd1, 0, 0);
    vecs[11] = mkv(5'b00000, 3'b000, 2'd1, 0, 0);
    vecs[12] = mkv(5'b11100, 3'b000, 2'd1, 0, 0);
    vecs[13] = mkv(5'b00000, 3'b000, 2'd1, 1, 0);
    vecs[14] = mkv(5'b10000, 3'b000, 2'd1, 1, 0);
    vecs[15] = mkv(5'b00000, 3'b000, 2'd1, 0, 0);
    vecs[16] = mkv(5'b00011, 3'b000, 2'd1, 0, 0);
    vecs[17] = mkv(5'b00001, 3'b000, 2'd2, 0, 0);
    vecs[18] = mkv(5'b00000, 3'b000, 2'd2, 0, 0);
    vecs[19] = mkv(5'b00001, 3'b010, 2'd2, 0, 0);
    vecs[20] = mkv(5'b11100, 3'b000, 2'd2, 0, 0);
    vecs[21] = mkv(5'b00010, 3'b000, 2'd2, 1, 0);
    vecs[22] = mkv(5'b00000, 3'b000, 2'd0, 0, 1);
    vecs[23] = mkv(5'b00000, 3'b000, 2'd0, 0, 0);
    vecs[24] = mkv(5'b11000, 3'b110, 2'd0, 0, 0);

    apply_reset();
    for (int i = 0; i < 25; i++) begin
      do_cycle(vecs[i].in);
      chk($sformatf("vec%0d_en", i), 8'({en_sec, en_min, en_hour}), 8'(vecs[i].en));
      chk($sformatf("vec%0d_mode", i), 8'(mode), 8'(vecs[i].md));
      chk($sformatf("vec%0d_blink", i), 8'(blink), 8'(vecs[i].bl));
      chk($sformatf("vec%0d_sec_clr", i), 8'(sec_clr), 8'(vecs[i].sc));
    end

    // Inactivity timeout from SET_MIN
    apply_reset();
    do_cycle(5'b00010); do_cycle(5'b00000); do_cycle(5'b00010); do_cycle(5'b00000);
    chk("tmo_enter_min", 8'(mode), 8'd2);
    for (int i = 1; i <= 10; i++) begin
      do_cycle(5'b10000);
      do_cycle(5'b00000);
      chk($sformatf("tmo_mode_t%0d", i), 8'(mode), (i == 10) ? 8'd0 : 8'd2);
      chk($sformatf("tmo_clr_t%0d", i), 8'(sec_clr), (i == 10) ? 8'd1 : 8'd0);
    end
    do_cycle(5'b00000);
    chk("tmo_clr_once", 8'(sec_clr), 8'd0);

    // Timeout restarted by an adjust press after tick 9
    do_cycle(5'b00010); do_cycle(5'b00000); do_cycle(5'b00010); do_cycle(5'b00000);
    for (int i = 1; i <= 19; i++) begin
      do_cycle(5'b10000);
      if (i == 9) begin
        do_cycle(5'b00001);
        chk("tmo_adj_step", 8'(en_min), 8'd1);
        do_cycle(5'b00000);
      end
      do_cycle(5'b00000);
      if (i >= 17) chk($sformatf("tmo2_mode_t%0d", i), 8'(mode), (i == 19) ? 8'd0 : 8'd2);
    end

    // Adjust held 800 cycles in SET_HOUR
    apply_reset();
    do_cycle(5'b00010); do_cycle(5'b00000);
    for (int k = 0; k < 800; k++) begin
      do_cycle(5'b00001);
      if (en_hour) hits.push_back(k);
    end
    do_cycle(5'b00000);
`ifdef KEY_REPEAT_EN
    chk("rep_count", 8'(hits.size()), 8'd4);
`else
    chk("rep_count", 8'(hits.size()), 8'd1);
`endif
    foreach (hits[k])
      chk($sformatf("rep_idx%0d", k), 8'(hits[k] / 10), 8'(((k == 0) ? 0 : REP_DLY + (k - 1) * REP_PER) / 10));

    // Reset asserted mid-repeat
    do_cycle(5'b00001);
    for (int k = 0; k < 550; k++) do_cycle(5'b00001);
    #2 nCR = 1'b0;
    #1;
    chk("midrst_en", 8'({en_sec, en_min, en_hour}), 8'd0);
    chk("midrst_mode", 8'(mode), 8'd0);
    chk("midrst_blink_clr", 8'({blink, sec_clr}), 8'd0);
    key_adj = 1'b0;
    repeat (2) @(negedge CP);
    nCR = 1'b1;
    model_reset();
    do_cycle(5'b00000);
    chk("postrst_mode", 8'(mode), 8'd0);

    // Random stimulus against the model
    km_l = 0; ka_l = 0;
    for (int c = 0; c < 4000; c++) begin
      ka_th = (c < 2000) ? 60 : 3;
      if ($urandom_range(0, 999) < 20)    km_l = ~km_l;
      if ($urandom_range(0, 999) < ka_th) ka_l = ~ka_l;
      do_cycle({($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom), km_l, ka_l});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
